ibus_sram_rsp: RTL and testbench

- Responder end of the core's instruction-fetch request/response port. Sits between the prefetch unit's ireq*/irsp* signals and a word-addressed on-chip instruction SRAM.
- Accepts fetch requests under a valid/ready handshake, performs a synchronous SRAM read and queues the results in an in-order response FIFO.
- Returns read data or a read error with independent response-side backpressure.
- Includes a side write port for loading the SRAM before or while fetching.

---
 rtl/ibus_sram_rsp_if.sv | 34 +++
 rtl/ibus_sram_rsp.sv | 102 ++++++++++
 tb/tb_ibus_sram_rsp.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ibus_sram_rsp_if.sv
// Instruction-fetch request/response bus between the prefetch unit (master)
// and the SRAM responder (slave).
interface ibus_sram_rsp_if;
    logic        ireqready_o;
    logic        ireqvalid_i;
    logic [1:0]  ireqhpl_i;
    logic [31:0] ireqaddr_i;
    logic        irspready_i;
    logic        irspvalid_o;
    logic        irsprerr_o;
    logic [31:0] irspdata_o;

    modport slave (
        output ireqready_o,
        input  ireqvalid_i,
        input  ireqhpl_i,
        input  ireqaddr_i,
        input  irspready_i,
        output irspvalid_o,
        output irsprerr_o,
        output irspdata_o
    );

    modport master (
        input  ireqready_o,
        output ireqvalid_i,
        output ireqhpl_i,
        output ireqaddr_i,
        output irspready_i,
        input  irspvalid_o,
        input  irsprerr_o,
        input  irspdata_o
    );
endinterface

// File: rtl/ibus_sram_rsp.sv
// Instruction-fetch responder: one-stage synchronous SRAM read feeding an
// in-order response FIFO, with credit-based request ready and a load port.
module ibus_sram_rsp #(
    parameter int unsigned C_MEM_SZX      = 10,
    parameter logic [31:0] C_BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned C_FIFO_DEPTH_X = 2,
    parameter logic [1:0]  C_MIN_HPL      = 2'b00
) (
    input  logic                 clk_i,
    input  logic                 clk_en_i,
    input  logic                 resetb_i,
    ibus_sram_rsp_if.slave       bus,
    input  logic                 wr_en_i,
    input  logic [C_MEM_SZX-1:0] wr_addr_i,
    input  logic [31:0]          wr_data_i
);

    localparam int unsigned DEPTH = 1 << C_FIFO_DEPTH_X;
    localparam int unsigned CW    = C_FIFO_DEPTH_X + 1;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic [31:0]               mem_q [2**C_MEM_SZX];
    rsp_t                      fifo_q [DEPTH];

    logic                      s1_vld_q, s1_err_q;
    logic [31:0]               s1_rdata_q;
    logic [C_FIFO_DEPTH_X-1:0] wptr_q, rptr_q;
    logic [CW-1:0]             cnt_q, cnt_d;

    logic [31:0]               offset;
    logic [C_MEM_SZX-1:0]      rd_idx;
    logic [2:0]                hpl_diff;
    logic                      req_err, ready, rsp_vld;
    logic                      accept, push, pop;
    logic [CW:0]               occ;
    rsp_t                      head;

    // Base is aligned to the SRAM size, so the offset's low bits and upper
    // bits directly give misalignment and range errors (underflow wraps high).
    assign offset   = bus.ireqaddr_i - C_BASE_ADDR;
    assign rd_idx   = offset[C_MEM_SZX+1:2];
    assign hpl_diff = {1'b0, bus.ireqhpl_i} - {1'b0, C_MIN_HPL};
    assign req_err  = (|offset[1:0]) | (|offset[31:C_MEM_SZX+2]) | hpl_diff[2];

    // Ready counts the in-flight s1 slot as a credit, so the push never stalls.
    assign occ     = {1'b0, cnt_q} + (CW+1)'(s1_vld_q);
    assign ready   = occ < (CW+1)'(DEPTH);
    assign rsp_vld = cnt_q != '0;

    assign accept = clk_en_i & bus.ireqvalid_i & ready;
    assign push   = clk_en_i & s1_vld_q;
    assign pop    = clk_en_i & rsp_vld & bus.irspready_i;

    assign head            = fifo_q[rptr_q];
    assign bus.ireqready_o = ready;
    assign bus.irspvalid_o = rsp_vld;
    assign bus.irsprerr_o  = rsp_vld & head.err;
    assign bus.irspdata_o  = rsp_vld ? head.data : 32'h0;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // SRAM and datapath storage carry no reset; validity lives in the
    // control registers below. Nonblocking read gives read-before-write.
    always_ff @(posedge clk_i) begin
        if (clk_en_i) begin
            if (accept)  s1_rdata_q <= mem_q[rd_idx];
            if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wptr_q] <= '{err: s1_err_q, data: s1_err_q ? 32'h0 : s1_rdata_q};
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            s1_vld_q <= 1'b0;
            s1_err_q <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
        end else if (clk_en_i) begin
            s1_vld_q <= accept;
            s1_err_q <= req_err;
            if (push) wptr_q <= wptr_q + C_FIFO_DEPTH_X'(1);
            if (pop)  rptr_q <= rptr_q + C_FIFO_DEPTH_X'(1);
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ibus_sram_rsp.sv
// Directed bench for ibus_sram_rsp: vector table plus multi-cycle sequences.
module tb_ibus_sram_rsp;

    logic        clk = 1'b0;
    logic        clk_en, rstb, wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    int          checks = 0;
    int          errors = 0;

    ibus_sram_rsp_if bif();

    ibus_sram_rsp #(
        .C_MEM_SZX(10), .C_BASE_ADDR(32'h0), .C_FIFO_DEPTH_X(2), .C_MIN_HPL(2'b01)
    ) dut (
        .clk_i(clk), .clk_en_i(clk_en), .resetb_i(rstb), .bus(bif),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  hpl;
        logic        err;
        logic [31:0] data;
    } vec_t;

    function automatic logic [31:0] word_val(input int k);
        if (k == 0)    return 32'h0000_0013;
        if (k == 1)    return 32'h0010_0093;
        if (k == 1023) return 32'hDEAD_BEEF;
        return 32'hA000_0000 + 32'(k);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input int k);
        wr_en = 1'b1; wr_addr = 10'(k); wr_data = word_val(k);
        tick();
        wr_en = 1'b0;
    endtask

    // Single fetch with irspready high; waits a bounded time for the response.
    task automatic fetch(input string name, input logic [31:0] addr, input logic [1:0] hpl,
                         input logic exp_err, input logic [31:0] exp_data);
        bit got;
        got = 1'b0;
        bif.ireqvalid_i = 1'b1; bif.ireqaddr_i = addr; bif.ireqhpl_i = hpl;
        tick();
        bif.ireqvalid_i = 1'b0;
        for (int n = 0; n < 6 && !got; n++) begin
            if (bif.irspvalid_o) begin
                got = 1'b1;
                chk({name, "_rerr"}, 32'(bif.irsprerr_o), 32'(exp_err));
                chk({name, "_data"}, bif.irspdata_o, exp_data);
            end
            tick();
        end
        if (!got) chk({name, "_timeout"}, 32'(got), 32'd1);
    endtask

    vec_t vecs [8];

    initial begin
        int acc_n, pop_n, exp_pop;
        bit acc, pp;
        logic [31:0] snap_data;
        logic        snap_vld, snap_rdy;

        vecs[0] = '{32'h0000_0008, 2'd1, 1'b0, word_val(2)};
        vecs[1] = '{32'h0000_003C, 2'd3, 1'b0, word_val(15)};
        vecs[2] = '{32'h0000_0002, 2'd1, 1'b1, 32'h0};
        vecs[3] = '{32'h0000_1000, 2'd1, 1'b1, 32'h0};
        vecs[4] = '{32'h0000_0000, 2'd0, 1'b1, 32'h0};
        vecs[5] = '{32'h0000_0FFC, 2'd2, 1'b0, word_val(1023)};
        vecs[6] = '{32'hFFFF_FFFC, 2'd1, 1'b1, 32'h0};
        vecs[7] = '{32'h0000_0007, 2'd3, 1'b1, 32'h0};

        clk_en = 1'b1; rstb = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        bif.ireqvalid_i = 1'b0; bif.ireqhpl_i = 2'd1; bif.ireqaddr_i = '0; bif.irspready_i = 1'b1;
        tick(); tick();
        chk("rst_valid", 32'(bif.irspvalid_o), 32'd0);
        chk("rst_rerr",  32'(bif.irsprerr_o),  32'd0);
        chk("rst_data",  bif.irspdata_o,       32'd0);
        chk("rst_ready", 32'(bif.ireqready_o), 32'd1);
        rstb = 1'b1;
        tick();

        for (int k = 0; k < 32; k++) wr_word(k);
        wr_word(1023);

        // back-to-back fetch of words 0 and 1, 2-cycle latency
        bif.ireqvalid_i = 1'b1; bif.ireqaddr_i = 32'h0;
        tick();
        chk("b2b_lat_valid0", 32'(bif.irspvalid_o), 32'd0);
        chk("b2b_ready0",     32'(bif.ireqready_o), 32'd1);
        bif.ireqaddr_i = 32'h4;
        tick();
        bif.ireqvalid_i = 1'b0;
        chk("b2b_valid1", 32'(bif.irspvalid_o), 32'd1);
        chk("b2b_data1",  bif.irspdata_o,       32'h0000_0013);
        chk("b2b_rerr1",  32'(bif.irsprerr_o),  32'd0);
        chk("b2b_ready1", 32'(bif.ireqready_o), 32'd1);
        tick();
        chk("b2b_valid2", 32'(bif.irspvalid_o), 32'd1);
        chk("b2b_data2",  bif.irspdata_o,       32'h0010_0093);
        tick();
        chk("b2b_drained", 32'(bif.irspvalid_o), 32'd0);

        for (int i = 0; i < 8; i++) fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].hpl,
                                          vecs[i].err, vecs[i].data);

        // backpressure: words 2..11, exactly 4 accepts while irspready is low
        bif.irspready_i = 1'b0; bif.ireqvalid_i = 1'b1; bif.ireqhpl_i = 2'd1;
        acc_n = 0;
        for (int c = 0; c < 8; c++) begin
            bif.ireqaddr_i = 32'(4 * (2 + acc_n));
            acc = bif.ireqready_o;
            tick();
            if (acc) acc_n++;
        end
        chk("bp_accepts", 32'(acc_n), 32'd4);
        chk("bp_ready_low", 32'(bif.ireqready_o), 32'd0);
        chk("bp_head", bif.irspdata_o, word_val(2));
        tick(); tick();
        chk("bp_head_stable", bif.irspdata_o, word_val(2));
        bif.ireqaddr_i = 32'(4 * (2 + acc_n));
        bif.irspready_i = 1'b1;
        tick();
        bif.irspready_i = 1'b0;
        chk("bp_one_pop_head", bif.irspdata_o, word_val(3));
        chk("bp_ready_after_pop", 32'(bif.ireqready_o), 32'd1);
        tick();
        acc_n++;
        chk("bp_ready_refull", 32'(bif.ireqready_o), 32'd0);
        chk("bp_head_after_acc", bif.irspdata_o, word_val(3));

        // full FIFO: pop + push on the same edge, then drain the remaining stream
        bif.irspready_i = 1'b1;
        exp_pop = 3; pop_n = 0;
        for (int c = 0; c < 40 && exp_pop < 12; c++) begin
            bif.ireqvalid_i = (acc_n < 10);
            bif.ireqaddr_i  = 32'(4 * (2 + acc_n));
            acc = bif.ireqvalid_i & bif.ireqready_o;
            pp  = bif.irspvalid_o;
            if (pp) begin
                chk($sformatf("wrap_data%0d", exp_pop), bif.irspdata_o, word_val(exp_pop));
                exp_pop++;
            end
            tick();
            if (acc) acc_n++;
            if (c == 0) chk("full_pp_head", bif.irspdata_o, word_val(4));
        end
        bif.ireqvalid_i = 1'b0;
        chk("wrap_all_popped", 32'(exp_pop), 32'd12);
        chk("wrap_accepts", 32'(acc_n), 32'd10);

        // clk_en low for 3 cycles mid-stream; write attempt to word 12 must not land
        acc_n = 0; exp_pop = 12;
        snap_data = '0; snap_vld = 1'b0; snap_rdy = 1'b0;
        for (int c = 0; c < 40 && exp_pop < 20; c++) begin
            clk_en  = !(c >= 3 && c < 6);
            wr_en   = !clk_en; wr_addr = 10'd12; wr_data = 32'hBAD0_BAD0;
            bif.ireqvalid_i = (acc_n < 8);
            bif.ireqaddr_i  = 32'(4 * (12 + acc_n));
            if (c == 3) begin
                snap_data = bif.irspdata_o; snap_vld = bif.irspvalid_o; snap_rdy = bif.ireqready_o;
            end
            if (c > 3 && c <= 6) begin
                chk($sformatf("cke_hold_data%0d", c), bif.irspdata_o, snap_data);
                chk($sformatf("cke_hold_vld%0d", c), 32'(bif.irspvalid_o), 32'(snap_vld));
                chk($sformatf("cke_hold_rdy%0d", c), 32'(bif.ireqready_o), 32'(snap_rdy));
            end
            acc = clk_en & bif.ireqvalid_i & bif.ireqready_o;
            pp  = clk_en & bif.irspvalid_o;
            if (pp) begin
                chk($sformatf("cke_data%0d", exp_pop), bif.irspdata_o, word_val(exp_pop));
                exp_pop++;
            end
            tick();
            if (acc) acc_n++;
        end
        clk_en = 1'b1; wr_en = 1'b0; bif.ireqvalid_i = 1'b0;
        chk("cke_all_popped", 32'(exp_pop), 32'd20);
        tick();
        fetch("cke_no_write", 32'd48, 2'd1, 1'b0, word_val(12));

        // reset with 3 responses queued
        bif.irspready_i = 1'b0; bif.ireqvalid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bif.ireqaddr_i = 32'(4 * (20 + i));
            tick();
        end
        bif.ireqvalid_i = 1'b0;
        tick();
        chk("mrst_queued", 32'(bif.irspvalid_o), 32'd1);
        #2 rstb = 1'b0;
        #1;
        chk("mrst_valid", 32'(bif.irspvalid_o), 32'd0);
        chk("mrst_ready", 32'(bif.ireqready_o), 32'd1);
        chk("mrst_data",  bif.irspdata_o,       32'd0);
        tick();
        rstb = 1'b1;
        bif.irspready_i = 1'b1;
        pop_n = 0;
        for (int c = 0; c < 5; c++) begin
            if (bif.irspvalid_o) pop_n++;
            tick();
        end
        chk("mrst_no_stale", 32'(pop_n), 32'd0);
        fetch("mrst_sram_kept", 32'h4, 2'd1, 1'b0, 32'h0010_0093);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
